// File: rtl/weight_frame_uc.sv
// Frame-capture control unit: gathers {min, max, measured} bytes from uart_rx,
// loads them into the datapath register and checks min <= max.
module weight_frame_uc #(
  parameter int TIMEOUT_CYCLES = 17360
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  input  logic        ack,
  output logic        reg_clear,
  output logic        reg_enable,
  output logic [23:0] reg_d,
  output logic        frame_done,
  output logic        frame_error,
  output logic [1:0]  error_code,
  output logic        overrun,
  output logic        busy,
  output logic [1:0]  byte_count,
  output logic [2:0]  state
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    RECV  = 3'b001,
    LOAD  = 3'b010,
    CHECK = 3'b011
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d, timer_inc;
  logic [1:0]    cnt_q, cnt_d;
  logic [23:0]   frame_q, frame_d;
  logic [1:0]    err_q, err_d;
  logic          ovr_q, ovr_d;
  logic          clr_q, clr_d;
  logic          en_q, en_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;

  assign timer_inc = timer_q + TW'(1);

  // Pulses are registered on the transition into the cycle they belong to,
  // so reg_enable lands in LOAD and the verdict lands in CHECK.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    clr_d   = 1'b0;
    en_d    = 1'b0;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    if (ack) ovr_d = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        cnt_d   = 2'd0;
        if (enable && rx_dv) begin
          frame_d[23:16] = rx_byte;
          err_d          = 2'b00;
          cnt_d          = 2'd1;
          state_d        = RECV;
        end
      end
      RECV: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
          timer_d = '0;
        end else if (rx_dv) begin
          timer_d = '0;
          if (cnt_q == 2'd1) begin
            frame_d[15:8] = rx_byte;
            cnt_d         = 2'd2;
          end else begin
            frame_d[7:0] = rx_byte;
            cnt_d        = 2'd3;
            en_d         = 1'b1;
            state_d      = LOAD;
          end
        end else if (timer_inc == TW'(TIMEOUT_CYCLES - 1)) begin
          ferr_d  = 1'b1;
          err_d   = 2'b01;
          cnt_d   = 2'd0;
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      LOAD: begin
        if (rx_dv) ovr_d = 1'b1;
        if (frame_q[23:16] > frame_q[15:8]) begin
          clr_d  = 1'b1;
          ferr_d = 1'b1;
        end else begin
          done_d = 1'b1;
        end
        state_d = CHECK;
      end
      CHECK: begin
        if (rx_dv) ovr_d = 1'b1;
        if (clr_q) err_d = 2'b10;
        cnt_d   = 2'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= 2'd0;
      frame_q <= 24'd0;
      err_q   <= 2'b00;
      ovr_q   <= 1'b0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      clr_q   <= clr_d;
      en_q    <= en_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign reg_clear   = clr_q;
  assign reg_enable  = en_q;
  assign reg_d       = frame_q;
  assign frame_done  = done_q;
  assign frame_error = ferr_q;
  assign error_code  = err_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q != IDLE);
  assign byte_count  = cnt_q;
  assign state       = state_q;
endmodule

// File: tb/tb_weight_frame_uc.sv
// Bench for weight_frame_uc: frame-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_weight_frame_uc;
  localparam int TO = 17360;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        ack = 1'b0;
  logic        reg_clear, reg_enable, frame_done, frame_error, overrun, busy;
  logic [23:0] reg_d;
  logic [1:0]  error_code, byte_count;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  weight_frame_uc #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .enable(enable), .rx_dv(rx_dv),
    .rx_byte(rx_byte), .ack(ack), .reg_clear(reg_clear),
    .reg_enable(reg_enable), .reg_d(reg_d), .frame_done(frame_done),
    .frame_error(frame_error), .error_code(error_code), .overrun(overrun),
    .busy(busy), .byte_count(byte_count), .state(state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: the frame is a list of received bytes; post counts
  // the two cycles (load, verdict) that follow a completed frame.
  logic [7:0]  m_bytes[$];
  logic [23:0] m_frame;
  logic [1:0]  m_err;
  logic        m_ovr, m_en, m_clr, m_done, m_ferr;
  int          m_idle, m_post;

  task automatic model_reset();
    m_bytes.delete();
    m_frame = 0; m_err = 0; m_ovr = 0;
    m_en = 0; m_clr = 0; m_done = 0; m_ferr = 0;
    m_idle = 0; m_post = 0;
  endtask

  task automatic model_step();
    logic bad;
    bad = (m_frame[23:16] > m_frame[15:8]);
    m_en = 0; m_clr = 0; m_done = 0; m_ferr = 0;
    if (ack) m_ovr = 0;
    if (m_post == 1) begin
      if (rx_dv) m_ovr = 1;
      m_post = 2;
      if (bad) begin m_clr = 1; m_ferr = 1; end
      else m_done = 1;
    end else if (m_post == 2) begin
      if (rx_dv) m_ovr = 1;
      m_post = 0;
      if (bad) m_err = 2'b10;
      m_bytes.delete();
    end else if (m_bytes.size() == 0) begin
      if (enable && rx_dv) begin
        m_frame[23:16] = rx_byte;
        m_err = 0;
        m_bytes.push_back(rx_byte);
        m_idle = 0;
      end
    end else if (!enable) begin
      m_bytes.delete();
    end else if (rx_dv) begin
      if (m_bytes.size() == 1) m_frame[15:8] = rx_byte;
      else m_frame[7:0] = rx_byte;
      m_bytes.push_back(rx_byte);
      m_idle = 0;
      if (m_bytes.size() == 3) begin m_post = 1; m_en = 1; end
    end else begin
      m_idle++;
      if (m_idle == TO - 1) begin
        m_ferr = 1; m_err = 2'b01; m_bytes.delete();
      end
    end
  endtask

  initial begin
    int es;
    model_reset();
    forever begin
      @(negedge clock);
      if (!reset) model_reset();
      es = (m_post == 1) ? 2 : (m_post == 2) ? 3 : (m_bytes.size() > 0) ? 1 : 0;
      chk("m_state", state, es);
      chk("m_busy", busy, es != 0);
      chk("m_byte_count", byte_count, m_bytes.size());
      chk("m_reg_d", reg_d, m_frame);
      chk("m_error_code", error_code, m_err);
      chk("m_overrun", overrun, m_ovr);
      chk("m_reg_enable", reg_enable, m_en);
      chk("m_reg_clear", reg_clear, m_clr);
      chk("m_frame_done", frame_done, m_done);
      chk("m_frame_error", frame_error, m_ferr);
      if (reset) model_step();
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    rx_dv = 1'b1; rx_byte = b;
    tick();
    rx_dv = 1'b0;
  endtask

  task automatic frame3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a); tick(); send(b); tick(); send(c);
  endtask

  initial begin
    tick(); tick();
    chk("rst_state", state, 0);
    chk("rst_reg_d", reg_d, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1; enable = 1'b1;
    tick();

    // 1: valid frame, bytes 4340 cycles apart
    send(8'h0A); repeat (4339) tick();
    send(8'h32); repeat (4339) tick();
    send(8'h1E);
    chk("s1_reg_enable", reg_enable, 1);
    chk("s1_reg_d", reg_d, 24'h0A321E);
    tick();
    chk("s1_frame_done", frame_done, 1);
    chk("s1_frame_error", frame_error, 0);
    chk("s1_busy_chk", busy, 1);
    tick();
    chk("s1_busy_low", busy, 0);
    chk("s1_error_code", error_code, 0);
    tick();

    // 2: range error then min == max
    frame3(8'h50, 8'h10, 8'h20);
    chk("s2_reg_enable", reg_enable, 1);
    chk("s2_reg_clear_t1", reg_clear, 0);
    tick();
    chk("s2_reg_clear", reg_clear, 1);
    chk("s2_frame_error", frame_error, 1);
    chk("s2_frame_done", frame_done, 0);
    tick();
    chk("s2_error_code", error_code, 2'b10);
    frame3(8'h20, 8'h20, 8'h20);
    tick();
    chk("s2_eq_done", frame_done, 1);
    tick();
    chk("s2_eq_code", error_code, 0);
    chk("s2_eq_reg_d", reg_d, 24'h202020);

    // 3: timeout after second byte
    send(8'h0A); tick(); send(8'h32);
    repeat (TO - 2) tick();
    chk("s3_no_err_early", frame_error, 0);
    chk("s3_still_recv", state, 1);
    tick();
    chk("s3_frame_error", frame_error, 1);
    chk("s3_error_code", error_code, 2'b01);
    chk("s3_state_idle", state, 0);
    chk("s3_reg_d_kept", reg_d, 24'h0A3220);
    tick();
    frame3(8'h01, 8'h02, 8'h03);
    tick();
    chk("s3_recover_done", frame_done, 1);
    tick();

    // 4: overrun during LOAD, sticky until ack
    frame3(8'h11, 8'h22, 8'h33);
    send(8'hFF);
    chk("s4_state_chk", state, 3);
    tick();
    chk("s4_overrun", overrun, 1);
    chk("s4_reg_d", reg_d, 24'h112233);
    frame3(8'h05, 8'h06, 8'h07);
    tick(); tick();
    chk("s4_overrun_held", overrun, 1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("s4_overrun_clr", overrun, 0);

    // 5: enable control
    send(8'h44);
    chk("s5_recv", state, 1);
    enable = 1'b0;
    tick();
    chk("s5_abort_state", state, 0);
    chk("s5_abort_count", byte_count, 0);
    send(8'h77);
    chk("s5_ignored_count", byte_count, 0);
    chk("s5_ignored_ovr", overrun, 0);
    chk("s5_ignored_state", state, 0);
    enable = 1'b1; tick();

    // 6: async reset mid-frame
    send(8'h09); tick();
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    chk("s6_state", state, 0);
    chk("s6_reg_d", reg_d, 0);
    chk("s6_byte_count", byte_count, 0);
    chk("s6_busy", busy, 0);
    tick(); reset = 1'b1; tick();
    frame3(8'h0A, 8'h32, 8'h1E);
    chk("s6_reg_enable", reg_enable, 1);
    tick();
    chk("s6_frame_done", frame_done, 1);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
